// File: rtl/npc_sequencer.sv
// Fetch-stage next-PC sequencer: owns the PC, drives the imem request handshake and
// applies D-stage redirects after the delay slot, parking them while fetch is stalled.
module npc_sequencer #(
   parameter logic [31:0] RESET_PC = 32'h0000_3000,
   parameter logic [31:0] EXC_VEC  = 32'h0000_4180
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall_f,
   input  logic        imem_ack,
   input  logic        pc_branch,
   input  logic [31:0] b_addr,
   input  logic        jump,
   input  logic [31:0] j_addr,
   input  logic        jump_reg,
   input  logic [31:0] jr_addr,
   input  logic        flush,
   output logic [31:0] pc_f,
   output logic [31:0] pc4_f,
   output logic        imem_req,
   output logic        fetch_valid,
   output logic        redirect_pending,
   output logic        pc_misalign
);

   typedef enum logic {StSeq, StPend} state_e;

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] pend_q, pend_d;
   logic        misalign_q, misalign_d;

   logic        fire;
   logic        redir;
   logic [31:0] target;

   assign imem_req = !reset && !stall_f && !flush;
   assign fire     = imem_req && imem_ack;
   assign redir    = jump_reg | jump | pc_branch;

   always_comb begin
      target = b_addr;
      if (jump_reg) begin
         target = jr_addr;
      end else if (jump) begin
         target = j_addr;
      end
      target[1:0] = 2'b00;
   end

   always_comb begin
      pc_d       = pc_q;
      pend_d     = pend_q;
      state_d    = state_q;
      misalign_d = misalign_q | (jump_reg && (jr_addr[1:0] != 2'b00));
      if (flush) begin
         pc_d    = EXC_VEC;
         pend_d  = '0;
         state_d = StSeq;
      end else begin
         unique case (state_q)
            StSeq: begin
               if (fire) begin
                  pc_d = redir ? target : pc_q + 32'd4;
               end else if (redir) begin
                  pend_d  = target;
                  state_d = StPend;
               end
            end
            StPend: begin
               // A fresh redirect in PEND supersedes the parked one, even on the releasing fire.
               if (fire) begin
                  pc_d    = redir ? target : pend_q;
                  state_d = StSeq;
               end else if (redir) begin
                  pend_d = target;
               end
            end
            default: state_d = StSeq;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q       <= RESET_PC;
         pend_q     <= '0;
         state_q    <= StSeq;
         misalign_q <= 1'b0;
      end else begin
         pc_q       <= pc_d;
         pend_q     <= pend_d;
         state_q    <= state_d;
         misalign_q <= misalign_d;
      end
   end

   assign pc_f             = pc_q;
   assign pc4_f            = pc_q + 32'd4;
   assign fetch_valid      = fire;
   assign redirect_pending = (state_q == StPend);
   assign pc_misalign      = misalign_q;

endmodule

// File: tb/tb_npc_sequencer.sv
// Scoreboard bench for npc_sequencer: directed scenarios then random traffic, checked
// against a behavioural model of PC sequencing.
module tb_npc_sequencer;

   localparam logic [31:0] RST_PC = 32'h0000_3000;
   localparam logic [31:0] EXC_PC = 32'h0000_4180;

   logic        clk = 1'b0;
   logic        reset, stall_f, imem_ack, pc_branch, jump, jump_reg, flush;
   logic [31:0] b_addr, j_addr, jr_addr;
   logic [31:0] pc_f, pc4_f;
   logic        imem_req, fetch_valid, redirect_pending, pc_misalign;

   always #5 clk = ~clk;

   npc_sequencer dut (
      .clk              (clk),
      .reset            (reset),
      .stall_f          (stall_f),
      .imem_ack         (imem_ack),
      .pc_branch        (pc_branch),
      .b_addr           (b_addr),
      .jump             (jump),
      .j_addr           (j_addr),
      .jump_reg         (jump_reg),
      .jr_addr          (jr_addr),
      .flush            (flush),
      .pc_f             (pc_f),
      .pc4_f            (pc4_f),
      .imem_req         (imem_req),
      .fetch_valid      (fetch_valid),
      .redirect_pending (redirect_pending),
      .pc_misalign      (pc_misalign)
   );

   typedef struct {
      logic [31:0] pc;
      logic        req;
      logic        fv;
      logic        pend;
      logic        mis;
   } exp_t;

   exp_t        exp_q[$];
   logic [31:0] fetch_q[$];
   int          n_checks = 0;
   int          n_fail   = 0;
   int          cyc_no   = 0;

   // Reference model state: PC, optional parked target, sticky misalign flag.
   logic [31:0] m_pc = RST_PC;
   bit          m_has_pend = 0;
   logic [31:0] m_pend = '0;
   bit          m_mis = 0;

   function automatic void chk(string name, logic [31:0] got, logic [31:0] want);
      n_checks++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s cycle %0d: got %h, expected %h", name, cyc_no, got, want);
      end
   endfunction

   task automatic cyc(input bit rst, input bit stl, input bit ack, input bit br,
                      input logic [31:0] ba, input bit j, input logic [31:0] ja,
                      input bit jr, input logic [31:0] jra, input bit fl);
      exp_t        e;
      bit          req, fv, any_redir;
      logic [31:0] tgt;
      @(negedge clk);
      reset = rst; stall_f = stl; imem_ack = ack; pc_branch = br; b_addr = ba;
      jump = j; j_addr = ja; jump_reg = jr; jr_addr = jra; flush = fl;
      req  = !rst && !stl && !fl;
      fv   = req && ack;
      e.pc = m_pc; e.req = req; e.fv = fv; e.pend = m_has_pend; e.mis = m_mis;
      exp_q.push_back(e);
      if (fv) fetch_q.push_back(m_pc);
      if (rst) begin
         m_pc = RST_PC; m_has_pend = 0; m_mis = 0;
      end else begin
         if (jr && (jra % 4) != 0) m_mis = 1;
         any_redir = jr || j || br;
         tgt = jr ? jra : (j ? ja : ba);
         tgt = tgt - (tgt % 4);
         if (fl) begin
            m_pc = EXC_PC; m_has_pend = 0;
         end else if (fv) begin
            if (any_redir)       m_pc = tgt;
            else if (m_has_pend) m_pc = m_pend;
            else                 m_pc = m_pc + 32'd4;
            m_has_pend = 0;
         end else if (any_redir) begin
            m_pend = tgt; m_has_pend = 1;
         end
      end
   endtask

   task automatic idle(input bit ack);
      cyc(0, 0, ack, 0, 0, 0, 0, 0, 0, 0);
   endtask

   // Monitor: per-cycle state record plus a fetch-address stream keyed on fetch_valid.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #2;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("pc_f", pc_f, e.pc);
            chk("pc4_f", pc4_f, e.pc + 32'd4);
            chk("imem_req", {31'd0, imem_req}, {31'd0, e.req});
            chk("fetch_valid", {31'd0, fetch_valid}, {31'd0, e.fv});
            chk("redirect_pending", {31'd0, redirect_pending}, {31'd0, e.pend});
            chk("pc_misalign", {31'd0, pc_misalign}, {31'd0, e.mis});
            cyc_no++;
         end
         if (fetch_valid === 1'b1) begin
            if (fetch_q.size() == 0) begin
               n_checks++; n_fail++;
               $display("FAIL fetch_stream cycle %0d: unexpected fetch at %h", cyc_no, pc_f);
            end else begin
               chk("fetch_addr", pc_f, fetch_q.pop_front());
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
      $fatal(1);
   end

   initial begin
      reset = 1; stall_f = 0; imem_ack = 0; pc_branch = 0; jump = 0; jump_reg = 0;
      flush = 0; b_addr = '0; j_addr = '0; jr_addr = '0;
      repeat (2) @(negedge clk);

      // Sequential fetch from reset, then a taken branch with fire.
      repeat (4) idle(1);
      cyc(0, 0, 1, 1, 32'h3100, 0, 0, 0, 0, 0);
      idle(1);
      // Jump while not acked parks, released on the later ack.
      cyc(0, 0, 0, 0, 0, 1, 32'h3200, 0, 0, 0);
      idle(0);
      idle(1);
      idle(1);
      // JR beats J, low bits dropped, misalign sticks.
      cyc(0, 0, 1, 0, 0, 1, 32'h3400, 1, 32'h3303, 0);
      repeat (2) idle(1);
      // Flush while parked.
      cyc(0, 1, 0, 0, 0, 1, 32'h3200, 0, 0, 0);
      cyc(0, 0, 1, 0, 0, 0, 0, 0, 0, 1);
      idle(1);
      idle(1);
      // Wraparound, then reset while parked.
      cyc(0, 0, 1, 0, 0, 1, 32'hFFFF_FFFC, 0, 0, 0);
      idle(1);
      idle(1);
      cyc(0, 0, 0, 1, 32'h0000_5555, 0, 0, 0, 0, 0);
      cyc(1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
      idle(1);
      // Last target wins when a second redirect lands in PEND.
      cyc(0, 0, 0, 1, 32'h0000_6000, 0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 1, 32'h0000_7000, 0, 0, 0);
      idle(1);
      idle(1);

      for (int i = 0; i < 3000; i++) begin
         bit rst, stl, ack, br, j, jr, fl;
         rst = ($urandom_range(0, 199) == 0);
         stl = ($urandom_range(0, 3) == 0);
         ack = ($urandom_range(0, 3) != 0);
         br  = ($urandom_range(0, 5) == 0);
         j   = ($urandom_range(0, 7) == 0);
         jr  = ($urandom_range(0, 9) == 0);
         fl  = ($urandom_range(0, 49) == 0);
         cyc(rst, stl, ack, br, $urandom, j, $urandom, jr, $urandom, fl);
      end

      idle(0);
      repeat (3) @(negedge clk);
      #3;
      chk("exp_queue_drained", exp_q.size(), 0);
      chk("fetch_queue_drained", fetch_q.size(), 0);
      $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
      $finish;
   end

endmodule
